// File: rtl/alien_formation_ctrl.sv
// Alien formation: alive matrix, march/descend stepping, laser hit resolution and pixel render.
// Optional FORMATION_SPEEDUP_EN: march period shrinks with alien_count (else fixed MAX_PERIOD).
module alien_formation_ctrl #(
  parameter int NUM_ROWS    = 5,
  parameter int NUM_COLUMNS = 8,
  parameter int ALIEN_W     = 16,
  parameter int ALIEN_H     = 16,
  parameter int SPACING_X   = 24,
  parameter int SPACING_Y   = 20,
  parameter int START_X     = 64,
  parameter int START_Y     = 48,
  parameter int STEP_X      = 4,
  parameter int STEP_Y      = 8,
  parameter int MIN_X       = 8,
  parameter int MAX_X       = 632,
  parameter int INVASION_Y  = 420,
  parameter int MIN_PERIOD  = 2,
  parameter int MAX_PERIOD  = 32
) (
  input  logic                                        clk_i,
  input  logic                                        reset_game,
  input  logic                                        frame_tick_i,
  input  logic                                        enable_i,
  input  logic [9:0]                                  scan_x_i,
  input  logic [9:0]                                  scan_y_i,
  input  logic                                        hit_valid_i,
  input  logic [9:0]                                  hit_x_i,
  input  logic [9:0]                                  hit_y_i,
  output logic                                        hit_ack_o,
  output logic [$clog2(NUM_ROWS)-1:0]                 hit_row_o,
  output logic [$clog2(NUM_COLUMNS)-1:0]              hit_col_o,
  output logic [5:0]                                  points_o,
  output logic [NUM_ROWS*NUM_COLUMNS-1:0]             alive_matrix_o,
  output logic [$clog2(NUM_ROWS*NUM_COLUMNS+1)-1:0]   alien_count_o,
  output logic [9:0]                                  form_x_o,
  output logic [9:0]                                  form_y_o,
  output logic                                        cleared_o,
  output logic                                        invaded_o,
  output logic                                        alien_pixel_o
);
  localparam int N  = NUM_ROWS * NUM_COLUMNS;
  localparam int RW = $clog2(NUM_ROWS);
  localparam int CW = $clog2(NUM_COLUMNS);
  localparam int NW = $clog2(N + 1);
  localparam int IW = $clog2(N);
  localparam int FW = $clog2(MAX_PERIOD + 1);

  typedef enum logic {MARCH, HALT} state_t;
  typedef struct packed {
    logic          in;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
  } loc_t;

  state_t        state_q;
  logic [N-1:0]  alive_q;
  logic [NW-1:0] count_q;
  logic [9:0]    form_x_q, form_y_q;
  logic          dir_q;  // 1 = moving right
  logic [FW-1:0] frame_cnt_q;
  logic          step_q, hit_ack_q, cleared_q, invaded_q, pixel_q;
  logic [RW-1:0] hit_row_q;
  logic [CW-1:0] hit_col_q;
  logic [5:0]    points_q;

  // Signed offset into the formation grid; negative or gap positions are not inside a box.
  function automatic loc_t locate(input logic [9:0] px, py, fx, fy);
    loc_t l;
    int   dx, dy;
    dx    = int'(px) - int'(fx);
    dy    = int'(py) - int'(fy);
    l.in  = (dx >= 0) && (dy >= 0) && (dx / SPACING_X < NUM_COLUMNS) && (dy / SPACING_Y < NUM_ROWS) &&
            (dx % SPACING_X < ALIEN_W) && (dy % SPACING_Y < ALIEN_H);
    l.row = RW'(dy / SPACING_Y);
    l.col = CW'(dx / SPACING_X);
    return l;
  endfunction

  function automatic logic [5:0] pts_of(input logic [RW-1:0] row);
    if (row == '0)              return 6'd30;
    else if (int'(row) <= 2)    return 6'd20;
    else                        return 6'd10;
  endfunction

  loc_t          hl, sl;
  logic [IW-1:0] hidx, sidx;
  logic          hit_now, scan_in, wrap, descend, inv_now;
  int            cmin, cmax, rmax, period, edge_l, edge_r;

  assign hl      = locate(hit_x_i, hit_y_i, form_x_q, form_y_q);
  assign sl      = locate(scan_x_i, scan_y_i, form_x_q, form_y_q);
  assign hidx    = IW'(int'(hl.row) * NUM_COLUMNS + int'(hl.col));
  assign sidx    = IW'(int'(sl.row) * NUM_COLUMNS + int'(sl.col));
  assign hit_now = (state_q == MARCH) && hit_valid_i && !hit_ack_q && hl.in && alive_q[hidx];
  assign scan_in = sl.in && alive_q[sidx];

  always_comb begin
    cmin = NUM_COLUMNS;
    cmax = 0;
    rmax = 0;
    for (int r = 0; r < NUM_ROWS; r++)
      for (int c = 0; c < NUM_COLUMNS; c++)
        if (alive_q[r*NUM_COLUMNS+c]) begin
          if (c < cmin) cmin = c;
          if (c > cmax) cmax = c;
          if (r > rmax) rmax = r;
        end
`ifdef FORMATION_SPEEDUP_EN
    period = MIN_PERIOD + int'(count_q);
    if (period > MAX_PERIOD) period = MAX_PERIOD;
`else
    period = MAX_PERIOD;
`endif
    edge_l  = int'(form_x_q) + cmin * SPACING_X;
    edge_r  = int'(form_x_q) + cmax * SPACING_X + ALIEN_W - 1;
    descend = dir_q ? (edge_r + STEP_X > MAX_X) : (edge_l < MIN_X + STEP_X);
    wrap    = int'(frame_cnt_q) + 1 >= period;
    // Evaluated the cycle after a step, so form_y and the alive matrix are already updated.
    inv_now = step_q && (int'(form_y_q) + rmax * SPACING_Y + ALIEN_H >= INVASION_Y);
  end

  always_ff @(posedge clk_i or posedge reset_game) begin
    if (reset_game) begin
      state_q     <= MARCH;
      alive_q     <= '1;
      count_q     <= NW'(N);
      form_x_q    <= 10'(START_X);
      form_y_q    <= 10'(START_Y);
      dir_q       <= 1'b1;
      frame_cnt_q <= '0;
      step_q      <= 1'b0;
      hit_ack_q   <= 1'b0;
      hit_row_q   <= '0;
      hit_col_q   <= '0;
      points_q    <= '0;
      cleared_q   <= 1'b0;
      invaded_q   <= 1'b0;
      pixel_q     <= 1'b0;
    end else begin
      hit_ack_q <= 1'b0;
      step_q    <= 1'b0;
      pixel_q   <= scan_in;
      if (state_q == MARCH) begin
        if (hit_now) begin
          alive_q[hidx] <= 1'b0;
          count_q       <= count_q - 1'b1;
          hit_ack_q     <= 1'b1;
          hit_row_q     <= hl.row;
          hit_col_q     <= hl.col;
          points_q      <= pts_of(hl.row);
          if (count_q == NW'(1)) begin
            cleared_q <= 1'b1;
            state_q   <= HALT;
          end
        end
        if (enable_i && frame_tick_i) begin
          if (wrap) begin
            frame_cnt_q <= '0;
            step_q      <= 1'b1;
            if (descend) begin
              form_y_q <= form_y_q + 10'(STEP_Y);
              dir_q    <= ~dir_q;
            end else if (dir_q) form_x_q <= form_x_q + 10'(STEP_X);
            else                form_x_q <= form_x_q - 10'(STEP_X);
          end else frame_cnt_q <= frame_cnt_q + 1'b1;
        end
        if (inv_now) begin
          invaded_q <= 1'b1;
          state_q   <= HALT;
        end
      end
    end
  end

  assign hit_ack_o      = hit_ack_q;
  assign hit_row_o      = hit_row_q;
  assign hit_col_o      = hit_col_q;
  assign points_o       = points_q;
  assign alive_matrix_o = alive_q;
  assign alien_count_o  = count_q;
  assign form_x_o       = form_x_q;
  assign form_y_o       = form_y_q;
  assign cleared_o      = cleared_q;
  assign invaded_o      = invaded_q;
  assign alien_pixel_o  = pixel_q;
endmodule
